// File: rtl/serial_adder_seq_if.sv
// Handshake/operand bundle for serial_adder_seq.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_seq_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_adder_seq.sv
// Multi-cycle add/subtract, DIGIT bits per clock with a registered carry.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output bus.ovf.
module serial_adder_seq #(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_seq_if.slave  bus
);
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder_seq: WIDTH must be at least 2");
  end
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_adder_seq: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   acc;
  logic               carry;
  logic [CW-1:0]      cnt;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic [DIGIT:0]       dig;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]     acc_next;

  always_comb begin
    dig      = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Concatenate-then-slice keeps the shift legal even when DIGIT == WIDTH.
    acc_cat  = {dig[DIGIT-1:0], acc};
    acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  logic msb_carry_in;
  // On the last digit the low bits of op_a/op_b are the operand MSB digit.
  assign msb_carry_in = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ dig[DIGIT-1];
  assign bus.ovf      = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            cnt    <= '0;
            acc    <= '0;
            state  <= BUSY;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          carry <= dig[DIGIT];
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            sum_q  <= acc_next;
            cout_q <= dig[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= msb_carry_in ^ dig[DIGIT];
`endif
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed and random checks of serial_adder_seq at W6/D2, W8/D4 and W8/D1.
module tb_serial_adder_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_adder_seq_if #(.WIDTH(6)) bus6 ();
  serial_adder_seq_if #(.WIDTH(8)) bus8d4 ();
  serial_adder_seq_if #(.WIDTH(8)) bus8d1 ();

  serial_adder_seq #(.WIDTH(6), .DIGIT(2)) dut6   (.clk(clk), .rst_n(rst_n), .bus(bus6.slave));
  serial_adder_seq #(.WIDTH(8), .DIGIT(4)) dut8d4 (.clk(clk), .rst_n(rst_n), .bus(bus8d4.slave));
  serial_adder_seq #(.WIDTH(8), .DIGIT(1)) dut8d1 (.clk(clk), .rst_n(rst_n), .bus(bus8d1.slave));

  // Issue one op on the 6-bit unit from a negedge; return result and cycles to done.
  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic s,
                        output logic [5:0] r, output logic c, output int lat);
    bus6.a = a; bus6.b = b; bus6.sub = s; bus6.start = 1'b1;
    @(negedge clk);
    bus6.start = 1'b0;
    lat = 1;
    while (bus6.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = bus6.sum;
    c = bus6.cout;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus6.start = 1'b1; bus6.sub = 1'b0; bus6.a = 6'h3F; bus6.b = 6'h3F;
    bus8d4.start = 1'b1; bus8d4.sub = 1'b0; bus8d4.a = '0; bus8d4.b = '0;
    bus8d1.start = 1'b1; bus8d1.sub = 1'b0; bus8d1.a = '0; bus8d1.b = '0;
    @(negedge clk);
    total += 5;
    if (bus6.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus6.busy); end
    if (bus6.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus6.done); end
    if (bus6.sum !== 6'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", bus6.sum); end
    if (bus6.cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", bus6.cout); end
    if (bus8d1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b exp=0", bus8d1.busy); end
`ifdef SERIAL_ADDER_OVF_EN
    total++;
    if (bus6.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus6.ovf); end
`endif
    bus6.start = 1'b0; bus8d4.start = 1'b0; bus8d1.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bus6.a = 6'h2A; bus6.b = 6'h15; bus6.sub = 1'b0; bus6.start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      bus6.start = 1'b0;
      total += 2;
      if (bus6.busy !== (cyc <= 3)) begin bad++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", cyc, bus6.busy, cyc <= 3); end
      if (bus6.done !== (cyc == 4)) begin bad++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", cyc, bus6.done, cyc == 4); end
      if (cyc == 4) begin
        total += 2;
        if (bus6.sum !== 6'h3F) begin bad++; $display("FAIL basic_sum got=%h exp=3f", bus6.sum); end
        if (bus6.cout !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b exp=0", bus6.cout); end
      end
    end
  endtask

  task automatic test_vectors;
    logic [5:0] va [4] = '{6'h3F, 6'h05, 6'h07, 6'h00};
    logic [5:0] vb [4] = '{6'h01, 6'h07, 6'h07, 6'h00};
    logic       vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [5:0] es [4] = '{6'h00, 6'h3E, 6'h00, 6'h00};
    logic       ec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [5:0] r;
    logic       c;
    int         lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], r, c, lat);
      total += 3;
      if (r !== es[i]) begin bad++; $display("FAIL vec%0d_sum got=%h exp=%h", i, r, es[i]); end
      if (c !== ec[i]) begin bad++; $display("FAIL vec%0d_cout got=%b exp=%b", i, c, ec[i]); end
      if (lat != 4) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=4", i, lat); end
      @(negedge clk);
    end
  endtask

  task automatic test_collision;
    int dones = 0;
    bus6.a = 6'h01; bus6.b = 6'h02; bus6.sub = 1'b0; bus6.start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      bus6.start = (cyc <= 2);
      bus6.a = 6'h30; bus6.b = 6'h30;
      if (bus6.done === 1'b1) begin
        dones++;
        total += 2;
        if (bus6.sum !== 6'h03) begin bad++; $display("FAIL collision_sum got=%h exp=03", bus6.sum); end
        if (cyc != 4) begin bad++; $display("FAIL collision_done_cycle got=%0d exp=4", cyc); end
      end
    end
    total += 2;
    if (dones != 1) begin bad++; $display("FAIL collision_done_count got=%0d exp=1", dones); end
    if (bus6.busy !== 1'b0) begin bad++; $display("FAIL collision_idle got=%b exp=0", bus6.busy); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    bus6.a = 6'h10; bus6.b = 6'h10; bus6.sub = 1'b0; bus6.start = 1'b1;
    @(negedge clk);
    bus6.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total += 3;
    if (bus6.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", bus6.busy); end
    if (bus6.sum !== 6'h00) begin bad++; $display("FAIL midreset_sum got=%h exp=00", bus6.sum); end
    if (bus6.cout !== 1'b0) begin bad++; $display("FAIL midreset_cout got=%b exp=0", bus6.cout); end
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (bus6.done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
  endtask

  task automatic test_back_to_back;
    bus6.a = 6'h0A; bus6.b = 6'h03; bus6.sub = 1'b0; bus6.start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      total++;
      if (bus6.done !== (cyc % 4 == 0)) begin bad++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", cyc, bus6.done, cyc % 4 == 0); end
      if (cyc % 4 == 0) begin
        total++;
        if (bus6.sum !== 6'h0D) begin bad++; $display("FAIL b2b_sum cyc=%0d got=%h exp=0d", cyc, bus6.sum); end
      end
    end
    bus6.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random6;
    logic [5:0] a, b, r;
    logic       s, c;
    logic [6:0] full;
    int         lat;
    for (int i = 0; i < 100; i++) begin
      a = 6'($urandom); b = 6'($urandom); s = 1'($urandom);
      full = s ? ({1'b0, a} + {1'b1, ~b} + 7'd1) : ({1'b0, a} + {1'b0, b});
      if (s) full[6] = (a >= b);
      run_op(a, b, s, r, c, lat);
      total += 3;
      if (r !== full[5:0]) begin bad++; $display("FAIL rand6_sum a=%h b=%h sub=%b got=%h exp=%h", a, b, s, r, full[5:0]); end
      if (c !== full[6]) begin bad++; $display("FAIL rand6_cout a=%h b=%h sub=%b got=%b exp=%b", a, b, s, c, full[6]); end
      if (lat != 4) begin bad++; $display("FAIL rand6_latency got=%0d exp=4", lat); end
    end
    @(negedge clk);
  endtask

  task automatic test_widths;
    logic [7:0] a, b, es;
    logic       s, ec;
    logic [8:0] full;
    int         l4, l1;
    logic [7:0] r4, r1;
    logic       c4, c1;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0: begin a = 8'hFF; b = 8'h01; s = 1'b0; end
        1: begin a = 8'h80; b = 8'h81; s = 1'b1; end
        2: begin a = 8'h5A; b = 8'hA5; s = 1'b0; end
        3: begin a = 8'h33; b = 8'h11; s = 1'b1; end
        default: begin a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); end
      endcase
      full = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      es = full[7:0];
      ec = s ? (a >= b) : full[8];
      bus8d4.a = a; bus8d4.b = b; bus8d4.sub = s; bus8d4.start = 1'b1;
      bus8d1.a = a; bus8d1.b = b; bus8d1.sub = s; bus8d1.start = 1'b1;
      l4 = 0; l1 = 0; r4 = '0; r1 = '0; c4 = 1'b0; c1 = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        @(negedge clk);
        bus8d4.start = 1'b0; bus8d1.start = 1'b0;
        if (bus8d4.done === 1'b1 && l4 == 0) begin l4 = cyc; r4 = bus8d4.sum; c4 = bus8d4.cout; end
        if (bus8d1.done === 1'b1 && l1 == 0) begin l1 = cyc; r1 = bus8d1.sum; c1 = bus8d1.cout; end
      end
      total += 6;
      if (l4 != 3) begin bad++; $display("FAIL w8d4_latency got=%0d exp=3", l4); end
      if (r4 !== es) begin bad++; $display("FAIL w8d4_sum a=%h b=%h sub=%b got=%h exp=%h", a, b, s, r4, es); end
      if (c4 !== ec) begin bad++; $display("FAIL w8d4_cout got=%b exp=%b", c4, ec); end
      if (l1 != 9) begin bad++; $display("FAIL w8d1_latency got=%0d exp=9", l1); end
      if (r1 !== es) begin bad++; $display("FAIL w8d1_sum a=%h b=%h sub=%b got=%h exp=%h", a, b, s, r1, es); end
      if (c1 !== ec) begin bad++; $display("FAIL w8d1_cout got=%b exp=%b", c1, ec); end
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf;
    logic [5:0] va [3] = '{6'h1F, 6'h20, 6'h02};
    logic [5:0] vb [3] = '{6'h01, 6'h01, 6'h01};
    logic       vs [3] = '{1'b0, 1'b1, 1'b0};
    logic [5:0] es [3] = '{6'h20, 6'h1F, 6'h03};
    logic       eo [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] r;
    logic       c;
    int         lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vs[i], r, c, lat);
      total += 2;
      if (r !== es[i]) begin bad++; $display("FAIL ovf%0d_sum got=%h exp=%h", i, r, es[i]); end
      if (bus6.ovf !== eo[i]) begin bad++; $display("FAIL ovf%0d_flag got=%b exp=%b", i, bus6.ovf, eo[i]); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_vectors();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    test_random6();
    test_widths();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
